// File: rtl/affine_pipe_pkg.sv
// Width helpers and parameter range checks for the affine product pipe.
// Every arithmetic width in the datapath is derived from W here.
package affine_pipe_pkg;

  function automatic int t1_w(input int w);
    return w + 9;
  endfunction

  function automatic int diff_w(input int w);
    return w + 1;
  endfunction

  function automatic int dsh_w(input int w);
    return w + 5;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w + 10;
  endfunction

  function automatic int num_w(input int w);
    return 2 * w + 11;
  endfunction

  function automatic int qw_w(input int w);
    return num_w(w);
  endfunction

  function automatic bit params_ok(
    input int w,
    input int kc,
    input int km,
    input int ds,
    input int div_sh,
    input int tag_w
  );
    return (w >= 4) && (w <= 64) &&
           (kc >= 0) && (kc <= 255) &&
           (km >= 0) && (km <= 255) &&
           (ds >= 0) && (ds <= 4) &&
           (div_sh >= 1) && (div_sh <= 8) &&
           (tag_w >= 1);
  endfunction

endpackage

// File: rtl/affine_product_pipe_if.sv
// Operand/result stream bundle: input beat with tag, result beat with tag.
// master = sequencer + result sink side, slave = the pipe.
interface affine_product_pipe_if
  import affine_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 4,
  parameter int RW    = 1,
  parameter int QW    = qw_w(W)
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     a;
  logic signed [W-1:0]     b;
  logic signed [W-1:0]     c;
  logic signed [W-1:0]     d;
  logic        [TAG_W-1:0] in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [QW-1:0]    q;
  logic        [RW-1:0]    rmd;
  logic        [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a, b, c, d, in_tag, out_ready,
    input  in_ready, out_valid, q, rmd, out_tag
  );

  modport slave (
    input  in_valid, a, b, c, d, in_tag, out_ready,
    output in_ready, out_valid, q, rmd, out_tag
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stage valid bits, global advance, flush/reset and busy for the pipe.
// Ports: clk, reset, flush_i, in_valid_i, out_ready_i -> adv_o, in_ready_o, out_valid_o, busy_o.
module pipe_stall_ctrl #(
  parameter int STAGES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  logic in_valid_i,
  input  logic out_ready_i,
  output logic adv_o,
  output logic in_ready_o,
  output logic out_valid_o,
  output logic busy_o
);
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic              accept;

  // in_ready is combinational from out_ready.
  assign adv_o       = !v_q[STAGES-1] || out_ready_i;
  assign in_ready_o  = adv_o;
  assign accept      = in_valid_i && adv_o && !flush_i;
  assign out_valid_o = v_q[STAGES-1];
  assign busy_o      = |v_q;

  always_comb begin
    v_d = v_q;
    if (flush_i) begin
      v_d = '0;
    end else if (adv_o) begin
      v_d = {v_q[STAGES-2:0], accept};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end
endmodule

// File: rtl/affine_product_pipe.sv
// 4-stage q = floor(((KC*c+KM)*(a-b) - (d<<DS)) / 2^DIV_SH), rmd = low bits.
// Ports: clk, reset, flush, io (operand/result stream, slave), busy.
module affine_product_pipe
  import affine_pipe_pkg::*;
#(
  parameter int W      = 32,
  parameter int KC     = 3,
  parameter int KM     = 1,
  parameter int DS     = 2,
  parameter int DIV_SH = 1,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  affine_product_pipe_if.slave io,
  output logic                busy
);
  localparam int T1W = t1_w(W);
  localparam int DW  = diff_w(W);
  localparam int SW  = dsh_w(W);
  localparam int PW  = prod_w(W);
  localparam int NW  = num_w(W);
  localparam int QW  = qw_w(W);

  localparam logic signed [T1W-1:0] KC_S = T1W'(KC);
  localparam logic signed [T1W-1:0] KM_S = T1W'(KM);

  if (!params_ok(W, KC, KM, DS, DIV_SH, TAG_W)) begin : g_bad_params
    $error("affine_product_pipe: parameter out of range");
  end

  logic adv;

  pipe_stall_ctrl #(.STAGES(4)) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .in_valid_i  (io.in_valid),
    .out_ready_i (io.out_ready),
    .adv_o       (adv),
    .in_ready_o  (io.in_ready),
    .out_valid_o (io.out_valid),
    .busy_o      (busy)
  );

  // S0: operand capture
  logic signed [W-1:0]     a0_q, b0_q, c0_q, d0_q;
  logic        [TAG_W-1:0] tag0_q;

  always_ff @(posedge clk) begin
    if (adv) begin
      a0_q   <= io.a;
      b0_q   <= io.b;
      c0_q   <= io.c;
      d0_q   <= io.d;
      tag0_q <= io.in_tag;
    end
  end

  // S1: T1, a-b, d<<DS
  logic signed [T1W-1:0]   t1_d, t1_q;
  logic signed [DW-1:0]    diff_d, diff_q;
  logic signed [SW-1:0]    dsh_d, dsh1_q;
  logic        [TAG_W-1:0] tag1_q;

  always_comb begin
    t1_d   = T1W'(c0_q) * KC_S + KM_S;
    diff_d = DW'(a0_q) - DW'(b0_q);
    dsh_d  = SW'(d0_q) <<< DS;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      t1_q   <= t1_d;
      diff_q <= diff_d;
      dsh1_q <= dsh_d;
      tag1_q <= tag0_q;
    end
  end

  // S2: product
  logic signed [PW-1:0]    prod_d, prod_q;
  logic signed [SW-1:0]    dsh2_q;
  logic        [TAG_W-1:0] tag2_q;

  always_comb begin
    prod_d = PW'(t1_q) * PW'(diff_q);
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      prod_q <= prod_d;
      dsh2_q <= dsh1_q;
      tag2_q <= tag1_q;
    end
  end

  // S3: numerator split into floor quotient and remainder
  logic signed [NW-1:0]     num_d;
  logic signed [QW-1:0]     q_d, q_q;
  logic        [DIV_SH-1:0] rmd_d, rmd_q;
  logic        [TAG_W-1:0]  tag3_q;

  always_comb begin
    num_d = NW'(prod_q) - NW'(dsh2_q);
    q_d   = num_d >>> DIV_SH;
    rmd_d = num_d[DIV_SH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      rmd_q  <= '0;
      tag3_q <= '0;
    end else if (adv) begin
      q_q    <= q_d;
      rmd_q  <= rmd_d;
      tag3_q <= tag2_q;
    end
  end

  assign io.q       = q_q;
  assign io.rmd     = rmd_q;
  assign io.out_tag = tag3_q;
endmodule

// File: tb/tb_affine_product_pipe.sv
// Directed self-checking bench for affine_product_pipe.
// Three instances: defaults, W=8, and KC=5/KM=0/DS=0/DIV_SH=2.
module tb_affine_product_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic fl0, fl1, fl2;
  logic busy0, busy1, busy2;
  int   n_chk = 0;
  int   n_fail = 0;

  affine_product_pipe_if #(.W(32), .TAG_W(4), .RW(1)) i0 ();
  affine_product_pipe_if #(.W(8),  .TAG_W(4), .RW(1)) i1 ();
  affine_product_pipe_if #(.W(32), .TAG_W(4), .RW(2)) i2 ();

  affine_product_pipe u0 (
    .clk(clk), .reset(rst), .flush(fl0), .io(i0), .busy(busy0)
  );

  affine_product_pipe #(.W(8)) u1 (
    .clk(clk), .reset(rst), .flush(fl1), .io(i1), .busy(busy1)
  );

  affine_product_pipe #(
    .KC(5), .KM(0), .DS(0), .DIV_SH(2)
  ) u2 (
    .clk(clk), .reset(rst), .flush(fl2), .io(i2), .busy(busy2)
  );

  task automatic idle_all();
    i0.in_valid = 0; i0.out_ready = 1; i0.in_tag = '0;
    i0.a = '0; i0.b = '0; i0.c = '0; i0.d = '0;
    i1.in_valid = 0; i1.out_ready = 1; i1.in_tag = '0;
    i1.a = '0; i1.b = '0; i1.c = '0; i1.d = '0;
    i2.in_valid = 0; i2.out_ready = 1; i2.in_tag = '0;
    i2.a = '0; i2.b = '0; i2.c = '0; i2.d = '0;
    fl0 = 0; fl1 = 0; fl2 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (i0.out_valid !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid out_valid=%b busy=%b want 0 0", i0.out_valid, busy0);
    end
    n_chk++;
    if (i0.q !== '0 || i0.rmd !== '0 || i0.out_tag !== '0) begin
      n_fail++;
      $display("FAIL reset_data q=%0d rmd=%0d tag=%0d want 0", i0.q, i0.rmd, i0.out_tag);
    end
    rst = 0;
    @(negedge clk);
    n_chk++;
    if (i0.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b want 1", i0.in_ready);
    end
  endtask

  // One beat into u0 with out_ready=1; checks latency, result, tag.
  task automatic beat0(
    input string name,
    input logic signed [31:0] a, b, c, d,
    input logic [3:0] tag,
    input logic signed [74:0] exp_q,
    input logic exp_r
  );
    int lat;
    @(negedge clk);
    i0.a = a; i0.b = b; i0.c = c; i0.d = d;
    i0.in_tag = tag; i0.in_valid = 1;
    @(negedge clk);
    i0.in_valid = 0;
    lat = 1;
    n_chk++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy got %b want 1", name, busy0);
    end
    while (i0.out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL %s_latency got %0d want 4", name, lat);
    end
    n_chk++;
    if (i0.q !== exp_q || i0.rmd !== exp_r || i0.out_tag !== tag) begin
      n_fail++;
      $display("FAIL %s_result q=%0d rmd=%0d tag=%0d want %0d %0d %0d",
               name, i0.q, i0.rmd, i0.out_tag, exp_q, exp_r, tag);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    beat0("basic", 32'sd10, 32'sd4, 32'sd2, 32'sd1, 4'd5, 75'sd19, 1'b1 ^ 1'b1);
  endtask

  task automatic test_negative();
    beat0("neg", 32'sd0, 32'sd1, 32'sd0, 32'sd0, 4'd9, -75'sd1, 1'b1);
  endtask

  task automatic test_w8_extreme();
    int lat;
    @(negedge clk);
    i1.a = 8'sh80; i1.b = 8'sh7f; i1.c = 8'sh80; i1.d = 8'sh80;
    i1.in_tag = 4'd3; i1.in_valid = 1;
    @(negedge clk);
    i1.in_valid = 0;
    lat = 1;
    while (i1.out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (i1.out_valid !== 1'b1 || i1.q !== 27'sd49088 || i1.rmd !== 1'b1) begin
      n_fail++;
      $display("FAIL w8_result v=%b q=%0d rmd=%0d want 1 49088 1",
               i1.out_valid, i1.q, i1.rmd);
    end
    @(negedge clk);
  endtask

  task automatic test_params();
    int lat;
    @(negedge clk);
    i2.a = 32'sd3; i2.b = 32'sd1; i2.c = 32'sd1; i2.d = 32'sd3;
    i2.in_tag = 4'd12; i2.in_valid = 1;
    @(negedge clk);
    i2.in_valid = 0;
    lat = 1;
    while (i2.out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (i2.out_valid !== 1'b1 || i2.q !== 75'sd1 || i2.rmd !== 2'd3 ||
        i2.out_tag !== 4'd12) begin
      n_fail++;
      $display("FAIL params_result v=%b q=%0d rmd=%0d tag=%0d want 1 1 3 12",
               i2.out_valid, i2.q, i2.rmd, i2.out_tag);
    end
    @(negedge clk);
  endtask

  // Beat t: a=3t, b=t, c=t, d=t -> numerator 6t^2-2t, q=3t^2-t, rmd=0.
  task automatic test_back_to_back();
    logic signed [74:0] exp_q [8];
    logic signed [74:0] hq;
    logic [3:0] htag;
    logic held;
    int nxt, got;
    exp_q = '{75'sd0, 75'sd2, 75'sd10, 75'sd24,
              75'sd44, 75'sd70, 75'sd102, 75'sd140};
    nxt = 0; got = 0; held = 0; hq = '0; htag = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      if (held) begin
        n_chk++;
        if (i0.out_valid !== 1'b1 || i0.q !== hq || i0.out_tag !== htag) begin
          n_fail++;
          $display("FAIL b2b_hold v=%b q=%0d tag=%0d want 1 %0d %0d",
                   i0.out_valid, i0.q, i0.out_tag, hq, htag);
        end
      end
      i0.out_ready = !(cyc >= 6 && cyc <= 10);
      i0.in_valid = (nxt < 8);
      i0.a = 32'(3 * nxt); i0.b = 32'(nxt);
      i0.c = 32'(nxt); i0.d = 32'(nxt);
      i0.in_tag = 4'(nxt);
      #1;
      n_chk++;
      if (i0.in_ready !== i0.out_ready) begin
        n_fail++;
        $display("FAIL b2b_in_ready cyc=%0d got %b want %b",
                 cyc, i0.in_ready, i0.out_ready);
      end
      if (i0.in_valid && i0.in_ready) nxt++;
      held = 0;
      if (i0.out_valid === 1'b1) begin
        if (!i0.out_ready) begin
          held = 1; hq = i0.q; htag = i0.out_tag;
        end else begin
          n_chk++;
          if (i0.out_tag !== 4'(got) || i0.q !== exp_q[got] || i0.rmd !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result tag=%0d q=%0d rmd=%0d want %0d %0d 0",
                     i0.out_tag, i0.q, i0.rmd, got, exp_q[got]);
          end
          got++;
        end
      end
    end
    @(negedge clk);
    i0.in_valid = 0;
    i0.out_ready = 1;
    n_chk++;
    if (got != 8 || nxt != 8) begin
      n_fail++;
      $display("FAIL b2b_count got %0d sent %0d want 8 8", got, nxt);
    end
    repeat (6) @(negedge clk);
    n_chk++;
    if (i0.out_valid !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain v=%b busy=%b want 0 0", i0.out_valid, busy0);
    end
  endtask

  // Three beats in flight, then kill (flush or reset) with a 4th in_valid.
  task automatic kill_run(input bit use_reset);
    int seen;
    string nm;
    nm = use_reset ? "rstmid" : "flush";
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i0.in_valid = 1;
      i0.a = 32'(20 + k); i0.b = 32'sd3;
      i0.c = 32'(7 + k); i0.d = 32'sd1;
      i0.in_tag = 4'(9 + k);
    end
    @(negedge clk);
    i0.in_tag = 4'd15;
    if (use_reset) rst = 1;
    else fl0 = 1;
    #1;
    n_chk++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy_before got %b want 1", nm, busy0);
    end
    @(negedge clk);
    i0.in_valid = 0;
    n_chk++;
    if (busy0 !== 1'b0 || i0.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_after busy=%b v=%b want 0 0", nm, busy0, i0.out_valid);
    end
    if (use_reset) begin
      n_chk++;
      if (i0.q !== '0 || i0.rmd !== '0 || i0.out_tag !== '0) begin
        n_fail++;
        $display("FAIL rstmid_data q=%0d rmd=%0d tag=%0d want 0",
                 i0.q, i0.rmd, i0.out_tag);
      end
      rst = 0;
    end else begin
      fl0 = 0;
    end
    @(negedge clk);
    if (use_reset) begin
      n_chk++;
      if (i0.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid_in_ready got %b want 1", i0.in_ready);
      end
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (i0.out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL %s_no_output saw %0d valid cycles want 0", nm, seen);
    end
  endtask

  task automatic test_flush();
    kill_run(1'b0);
  endtask

  task automatic test_reset_mid();
    kill_run(1'b1);
  endtask

  initial begin
    idle_all();
    rst = 1;
    test_reset();
    test_basic();
    test_negative();
    test_w8_extreme();
    test_params();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
